// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: shadow EX/MEM/WB write metadata driving EX forwarding,
// ID-stage WB bypass, load-use stalls and saturating stall/retire counters.
module pipe_hazard_unit #(
    parameter int REG_AW      = 2,
    parameter int NUM_SRC     = 2,
    parameter int CNT_W       = 16,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    output logic                      stall,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [NUM_SRC-1:0]        id_bypass,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          retire_count
);

    typedef struct packed {
        logic                      v;
        logic [NUM_SRC*REG_AW-1:0] src;
        logic [NUM_SRC-1:0]        used;
        logic [REG_AW-1:0]         dst;
        logic                      rw;
        logic                      mr;
    } ex_ent_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              rw;
        logic              mr;
    } mem_ent_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              rw;
    } wb_ent_t;

    ex_ent_t           ex_q, ex_d;
    mem_ent_t          mem_q, mem_d;
    wb_ent_t           wb_q, wb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic               hazard;
    logic [NUM_SRC-1:0] id_ex_load_hit;
    logic [NUM_SRC-1:0] ex_mem_match;
    logic [NUM_SRC-1:0] ex_wb_match;

    // A source matches a stage only if it is read and the stage really writes it.
    function automatic logic src_hit(
        input logic              used,
        input logic              v,
        input logic              rw,
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] d
    );
        src_hit = used && v && rw && (a == d)
                  && !(ZERO_REG_EN && (a == '0));
    endfunction

    always_comb begin
        id_ex_load_hit = '0;
        id_bypass      = '0;
        ex_mem_match   = '0;
        ex_wb_match    = '0;
        fwd_sel        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_ex_load_hit[i] = ex_q.mr && src_hit(
                id_src_used[i], ex_q.v, ex_q.rw,
                id_src_addr[i*REG_AW +: REG_AW], ex_q.dst);
            id_bypass[i] = src_hit(
                id_src_used[i], wb_q.v, wb_q.rw,
                id_src_addr[i*REG_AW +: REG_AW], wb_q.dst);
            ex_mem_match[i] = src_hit(
                ex_q.used[i], mem_q.v, mem_q.rw,
                ex_q.src[i*REG_AW +: REG_AW], mem_q.dst);
            ex_wb_match[i] = src_hit(
                ex_q.used[i], wb_q.v, wb_q.rw,
                ex_q.src[i*REG_AW +: REG_AW], wb_q.dst);
            // Youngest writer wins; a load in MEM has no data yet.
            if (ex_mem_match[i] && !mem_q.mr) begin
                fwd_sel[2*i +: 2] = 2'd1;
            end else if (ex_wb_match[i]) begin
                fwd_sel[2*i +: 2] = 2'd2;
            end
        end
        hazard = id_valid && (|id_ex_load_hit);
        stall  = hazard && !flush;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.v    = 1'b1;
            ex_d.src  = id_src_addr;
            ex_d.used = id_src_used;
            ex_d.dst  = id_dst_addr;
            ex_d.rw   = id_reg_write;
            ex_d.mr   = id_mem_read;
        end

        mem_d.v   = ex_q.v;
        mem_d.dst = ex_q.dst;
        mem_d.rw  = ex_q.rw;
        mem_d.mr  = ex_q.mr;

        wb_d.v   = mem_q.v;
        wb_d.dst = mem_q.dst;
        wb_d.rw  = mem_q.rw;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        retire_cnt_d = retire_cnt_q;
        if (wb_q.v && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_count  = stall_cnt_q;
    assign retire_count = retire_cnt_q;

endmodule
